sram_port0_ctrl: RTL and testbench

// Initiator for the RW port (port 0) of the 32x512 OpenRAM SRAM macro. Converts a valid/ready

---
 rtl/sram_port0_ctrl.sv | 116 +++++++++++
 tb/tb_sram_port0_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port0_ctrl.sv
// Port-0 (RW) initiator for the 32x512 OpenRAM macro: turns a request stream into registered
// macro strobes, returns read data on a response channel, and optionally clears the array after reset.
module sram_port0_ctrl #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_WMASKS = 4,
  parameter int                    READ_LAT   = 1,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  // Handshakes: a beat transfers at a rising edge where valid & ready are both high. req_ready
  // is a registered image of "state is IDLE"; rsp_valid/rsp_rdata hold until taken.
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD_WAIT, S_RSP} state_t;

  localparam logic [1:0] LAT_END = 2'(READ_LAT);

  state_t                state;
  logic [ADDR_WIDTH:0]   sweep_cnt;
  logic [ADDR_WIDTH:0]   sweep_next;
  logic [1:0]            lat_cnt;

  // Extra MSB of the sweep counter flags that the last word has just been issued.
  assign sweep_next = sweep_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT_EN ? S_INIT : S_IDLE;
      sweep_cnt   <= '0;
      lat_cnt     <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      init_done   <= 1'b0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      case (state)
        S_INIT: begin
          sram_csb0   <= 1'b0;
          sram_web0   <= 1'b0;
          sram_wmask0 <= '1;
          sram_addr0  <= sweep_cnt[ADDR_WIDTH-1:0];
          sram_din0   <= INIT_VALUE;
          sweep_cnt   <= sweep_next;
          if (sweep_next[ADDR_WIDTH]) begin
            state     <= S_IDLE;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          init_done <= 1'b1;
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            sram_csb0  <= 1'b0;
            sram_addr0 <= req_addr;
            if (req_we) begin
              sram_web0   <= 1'b0;
              sram_wmask0 <= req_wmask;
              sram_din0   <= req_wdata;
            end else begin
              req_ready <= 1'b0;
              lat_cnt   <= '0;
              state     <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          // First edge here is the macro sampling edge; data is captured READ_LAT edges later.
          if (lat_cnt == LAT_END) begin
            rsp_rdata <= sram_dout0;
            rsp_valid <= 1'b1;
            state     <= S_RSP;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Bench for sram_port0_ctrl: behavioural macro model, reference memory, expected-data queue
// checked when responses appear, and directed sweep/reset/handshake scenarios.
module tb_sram_port0_ctrl;

  localparam int AW       = 9;
  localparam int DW       = 32;
  localparam int MW       = 4;
  localparam int READ_LAT = 1;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [MW-1:0] req_wmask;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          sram_csb0;
  logic          sram_web0;
  logic [MW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] mem [512];
  bit rsp_seen = 1'b0;

  sram_port0_ctrl #(.READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wmask(req_wmask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: samples at the rising edge, read data valid one cycle later.
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < MW; b++)
          if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare each new response against the oldest expected value.
  always @(negedge clk) begin
    if (rsp_valid && !rsp_seen) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
      else check("rsp_data", rsp_rdata, exp_q.pop_front());
    end
    rsp_seen <= rsp_valid;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"}, {sram_csb0, sram_web0, sram_wmask0, sram_addr0, rsp_valid, req_ready, init_done},
          {1'b1, 1'b1, 4'h0, 9'h000, 1'b0, 1'b0, 1'b0});
    check({tag, "_data"}, {sram_din0, rsp_rdata}, 64'h0);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_vals(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_sweep(input int abort_at, output int strobes, output int bad);
    int cyc;
    strobes = 0;
    bad     = 0;
    cyc     = 0;
    while (cyc < 700) begin
      @(negedge clk);
      cyc++;
      if (!sram_csb0 && !sram_web0) begin
        if (sram_addr0 != strobes[8:0] || sram_wmask0 != 4'hF || sram_din0 != 32'h0 ||
            (req_ready && !init_done)) bad++;
        strobes++;
      end else begin
        bad++;
      end
      if (init_done || (abort_at >= 0 && strobes >= abort_at)) break;
    end
  endtask

  task automatic full_sweep(input string tag);
    int s, b;
    run_sweep(-1, s, b);
    check({tag, "_strobes"}, s, 512);
    check({tag, "_bad"}, b, 0);
    check({tag, "_done"}, init_done, 1'b1);
    @(negedge clk);
    check({tag, "_idle"}, {sram_csb0, req_ready, init_done}, 3'b111);
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
  endtask

  // Present a request from the next falling edge; returns just after the accepting edge.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [MW-1:0] m,
                      input logic [DW-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wmask = m;
    req_wdata = d;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
    send(1'b1, a, m, d);
    for (int b = 0; b < MW; b++)
      if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
    @(negedge clk);
    req_valid = 1'b0;
    check("wr_strobe", {sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0},
          {1'b0, 1'b0, m, a, d});
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int hold);
    int k;
    exp_q.push_back(exp);
    rsp_ready = (hold == 0);
    send(1'b0, a, 4'h0, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("rd_strobe", {sram_csb0, sram_web0, sram_wmask0, sram_addr0}, {1'b0, 1'b1, 4'h0, a});
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rd_latency", k, READ_LAT + 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("rsp_hold%0d", i), {rsp_valid, rsp_rdata, req_ready, sram_csb0},
            {1'b1, exp, 1'b0, 1'b1});
    end
    rsp_ready = 1'b1;
    k = 0;
    while (rsp_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("rsp_drop", k, 1);
  endtask

  initial begin
    int s, b;
    logic [AW-1:0] ra;
    logic [MW-1:0] rm;
    logic [DW-1:0] rd;
    logic [DW-1:0] b2b_d [4];

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wmask = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    pulse_reset("rst_init");

    // Sweep aborted at word 200 by reset, then a full sweep from word 0.
    run_sweep(200, s, b);
    check("sweep_abort_strobes", s, 200);
    check("sweep_abort_bad", b, 0);
    pulse_reset("rst_sweep");
    full_sweep("sweep1");

    do_write(9'h1A5, 4'hF, 32'hDEADBEEF);
    do_read(9'h1A5, 32'hDEADBEEF, 0);

    do_write(9'h0C3, 4'hF, 32'h11223344);
    do_write(9'h0C3, 4'b0101, 32'hAABBCCDD);
    do_read(9'h0C3, 32'h11BB33DD, 0);

    do_read(9'h1A5, 32'hDEADBEEF, 5);

    // Four back-to-back writes with req_valid held high.
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0)
        check($sformatf("b2b_wr%0d", i - 1), {req_ready, sram_csb0, sram_web0, sram_addr0, sram_din0},
              {1'b1, 1'b0, 1'b0, 9'(9'h010 + 9'(i - 1)), b2b_d[i-1]});
      if (i < 4) begin
        b2b_d[i]  = $urandom;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 9'(9'h010 + 9'(i));
        req_wmask = 4'hF;
        req_wdata = b2b_d[i];
        ref_mem[9'h010 + 9'(i)] = b2b_d[i];
      end else begin
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_idle", {sram_csb0, sram_web0}, 2'b11);
    do_read(9'h012, ref_mem[9'h012], 0);

    for (int i = 0; i < 6; i++) begin
      ra = 9'($urandom_range(0, 511));
      rm = 4'($urandom_range(0, 15));
      rd = $urandom;
      do_write(ra, rm, rd);
      do_read(ra, ref_mem[ra], $urandom_range(0, 2));
    end

    // Reset while a read is in flight: the response must be dropped.
    rsp_ready = 1'b1;
    send(1'b0, 9'h1A5, 4'h0, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    pulse_reset("rst_rdwait");
    full_sweep("sweep2");
    do_read(9'h1A5, 32'h0, 0);

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
